// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: run/halt/single-step clock-enable generator for the processor core.
// Latency: raw HALT/STEP to debounced level is 2+DEBOUNCE_CYCLES edges; clkEn is registered on tick edges.
// Backpressure: none; clkEn is a free-running strobe and the core must accept every pulse.
//
// Ports:
//   CLK_osc  oscillator clock, all state on rising edge
//   RST      asynchronous active-high reset
//   HALT     raw halt switch (level, asynchronous)
//   STEP     raw step button (asynchronous)
//   clkEn    one-cycle enable, core advances one instruction per high cycle
//   halted   high while in HALTED state
//   enCount  number of clkEn pulses issued since reset (wraps)
module proc_run_ctrl #(
  parameter int DIV             = 50000000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             CLK_osc,
  input  logic             RST,
  input  logic             HALT,
  input  logic             STEP,
  output logic             clkEn,
  output logic             halted,
  output logic [CNT_W-1:0] enCount
);

  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } runState_t;

  runState_t        state;
  runState_t        stateNxt;
  logic             clkEnNxt;
  logic             pendClr;

  logic             haltMeta, haltSync, haltDeb;
  logic             stepMeta, stepSync, stepDeb;
  logic [DB_W-1:0]  haltDbCnt, stepDbCnt;
  logic             haltUpd, stepUpd;
  logic             stepRise;
  logic             stepPending;
  logic [DIV_W-1:0] divCnt;
  logic             tick;

  // Two-flop synchronizers for the asynchronous panel inputs.
  always_ff @(posedge CLK_osc or posedge RST) begin
    if (RST) begin
      haltMeta <= 1'b0;
      haltSync <= 1'b0;
      stepMeta <= 1'b0;
      stepSync <= 1'b0;
    end else begin
      haltMeta <= HALT;
      haltSync <= haltMeta;
      stepMeta <= STEP;
      stepSync <= stepMeta;
    end
  end

  // The debounced level flips on the edge where the counter would reach
  // DEBOUNCE_CYCLES; any return to the accepted level restarts the count.
  assign haltUpd = (haltSync != haltDeb) && (haltDbCnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign stepUpd = (stepSync != stepDeb) && (stepDbCnt == DB_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge CLK_osc or posedge RST) begin
    if (RST) begin
      haltDeb   <= 1'b0;
      haltDbCnt <= '0;
    end else if (haltSync == haltDeb) begin
      haltDbCnt <= '0;
    end else if (haltUpd) begin
      haltDeb   <= haltSync;
      haltDbCnt <= '0;
    end else begin
      haltDbCnt <= haltDbCnt + DB_W'(1);
    end
  end

  always_ff @(posedge CLK_osc or posedge RST) begin
    if (RST) begin
      stepDeb   <= 1'b0;
      stepDbCnt <= '0;
    end else if (stepSync == stepDeb) begin
      stepDbCnt <= '0;
    end else if (stepUpd) begin
      stepDeb   <= stepSync;
      stepDbCnt <= '0;
    end else begin
      stepDbCnt <= stepDbCnt + DB_W'(1);
    end
  end

  // Rising edge of debounced STEP, detected on the edge the level is accepted.
  // Presses while running are discarded.
  assign stepRise = stepUpd && stepSync && (state == HALTED);

  // Free-running divider; the tick is the edge on which divCnt sits at DIV-1.
  assign tick = (divCnt == DIV_W'(DIV - 1));

  always_ff @(posedge CLK_osc or posedge RST) begin
    if (RST) begin
      divCnt <= '0;
    end else if (tick) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  always_comb begin
    stateNxt = state;
    clkEnNxt = 1'b0;
    pendClr  = 1'b0;
    if (tick) begin
      case (state)
        RUN: begin
          if (haltDeb) begin
            stateNxt = HALTED;
          end else begin
            clkEnNxt = 1'b1;
          end
        end
        HALTED: begin
          if (!haltDeb) begin
            stateNxt = RUN;
            clkEnNxt = 1'b1;
            pendClr  = 1'b1;
          end else if (stepPending) begin
            clkEnNxt = 1'b1;
            pendClr  = 1'b1;
          end
        end
        default: stateNxt = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK_osc or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      clkEn       <= 1'b0;
      halted      <= 1'b0;
      enCount     <= '0;
      stepPending <= 1'b0;
    end else begin
      state  <= stateNxt;
      clkEn  <= clkEnNxt;
      halted <= (stateNxt == HALTED);
      if (clkEnNxt) begin
        enCount <= enCount + CNT_W'(1);
      end
      // A press landing on the servicing tick wins over the clear, so it is
      // kept for the next tick; leaving HALTED always drops it.
      if (stepRise && (stateNxt == HALTED)) begin
        stepPending <= 1'b1;
      end else if (pendClr) begin
        stepPending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: directed bench for proc_run_ctrl with DIV=4, DEBOUNCE_CYCLES=3, CNT_W=4.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_proc_run_ctrl;

  logic       CLK_osc;
  logic       RST;
  logic       HALT;
  logic       STEP;
  logic       clkEn;
  logic       halted;
  logic [3:0] enCount;

  int testsRun  = 0;
  int testsFail = 0;
  int edgeNum   = 0;
  int pulses;

  proc_run_ctrl #(
    .DIV            (4),
    .DEBOUNCE_CYCLES(3),
    .CNT_W          (4)
  ) dut (
    .CLK_osc(CLK_osc),
    .RST    (RST),
    .HALT   (HALT),
    .STEP   (STEP),
    .clkEn  (clkEn),
    .halted (halted),
    .enCount(enCount)
  );

  initial CLK_osc = 1'b0;
  always #5 CLK_osc = ~CLK_osc;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFail++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, edgeNum, got, exp);
    end
  endtask

  task automatic nextEdge();
    @(posedge CLK_osc);
    edgeNum++;
    #1;
  endtask

  // Advance n edges, accumulating clkEn pulses into the shared counter.
  task automatic runEdges(input int n);
    for (int i = 0; i < n; i++) begin
      nextEdge();
      if (clkEn) pulses++;
    end
  endtask

  initial begin
    RST  = 1'b1;
    HALT = 1'b0;
    STEP = 1'b0;
    #23;
    checkVal("rst_clkEn", clkEn, 0);
    checkVal("rst_halted", halted, 0);
    checkVal("rst_enCount", enCount, 0);
    RST     = 1'b0;
    edgeNum = 0;

    // 1: free run, pulse after every 4th edge
    for (int k = 1; k <= 12; k++) begin
      nextEdge();
      checkVal("run_clkEn", clkEn, (k % 4 == 0) ? 1 : 0);
      checkVal("run_enCount", enCount, k / 4);
      checkVal("run_halted", halted, 0);
    end

    // 2: HALT raised after edge 12, debounced at 17; tick 16 still pulses, tick 20 halts
    HALT   = 1'b1;
    pulses = 0;
    runEdges(8);
    checkVal("halt_pulses", pulses, 1);
    checkVal("halt_halted", halted, 1);
    checkVal("halt_enCount", enCount, 4);
    pulses = 0;
    runEdges(40);
    checkVal("halt_idle_pulses", pulses, 0);
    checkVal("halt_idle_enCount", enCount, 4);
    checkVal("halt_idle_halted", halted, 1);

    // 3: STEP held 10 cycles from edge 60; debounced rise at 65, serviced on tick 68
    STEP   = 1'b1;
    pulses = 0;
    runEdges(10);
    STEP = 1'b0;
    runEdges(6);
    checkVal("step_pulses", pulses, 1);
    checkVal("step_enCount", enCount, 5);
    checkVal("step_halted", halted, 1);

    // 4: 2-cycle glitch on STEP must be ignored
    STEP   = 1'b1;
    pulses = 0;
    runEdges(2);
    STEP = 1'b0;
    runEdges(14);
    checkVal("glitch_pulses", pulses, 0);
    checkVal("glitch_enCount", enCount, 5);

    // 5: step pending (rise at 97) then HALT drop (debounced at 99): one pulse at 100
    STEP = 1'b1;
    runEdges(2);
    HALT = 1'b0;
    for (int e = 95; e <= 108; e++) begin
      nextEdge();
      if (e == 101) STEP = 1'b0;
      checkVal("resume_clkEn", clkEn, (e == 100 || e == 104 || e == 108) ? 1 : 0);
    end
    checkVal("resume_enCount", enCount, 8);
    checkVal("resume_halted", halted, 0);

    // 6: halt again (tick 116), queue a step (rise at 121), reset at edge 122 + 3
    HALT = 1'b1;
    runEdges(8);
    checkVal("rehalt_halted", halted, 1);
    checkVal("rehalt_enCount", enCount, 9);
    STEP = 1'b1;
    runEdges(6);
    #2;
    RST  = 1'b1;
    HALT = 1'b0;
    STEP = 1'b0;
    #1;
    checkVal("arst_clkEn", clkEn, 0);
    checkVal("arst_halted", halted, 0);
    checkVal("arst_enCount", enCount, 0);
    @(negedge CLK_osc);
    RST     = 1'b0;
    edgeNum = 0;
    pulses  = 0;
    for (int k = 1; k <= 80; k++) begin
      nextEdge();
      if (clkEn) pulses++;
      if (k <= 4) checkVal("post_clkEn", clkEn, (k == 4) ? 1 : 0);
      if (k == 60) checkVal("wrap_pre", enCount, 15);
      if (k == 64) checkVal("wrap_zero", enCount, 0);
    end
    checkVal("post_pulses", pulses, 20);
    checkVal("post_enCount", enCount, 4);
    checkVal("post_halted", halted, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Clock-enable and run-control stage that sits directly upstream of the processor core.
- Takes the free-running oscillator plus raw front-panel HALT switch and STEP button, debounces them, and divides the oscillator down.
- Emits a single-cycle enable pulse that advances the core by one instruction; core, PC and display all update only on that pulse.
- Provides run, halted and single-step modes, and a count of issued enables for bench and display use.

Parameters:
- DIV, 50000000, oscillator cycles per enable pulse in run mode; legal range ≥2.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before a switch/button level is accepted; legal range ≥1.
- CNT_W, 16, width of the enable counter.

Ports:
- CLK_osc  input  1  oscillator clock; all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- HALT  input  1  raw front-panel halt switch (level), asynchronous to CLK_osc.
- STEP  input  1  raw front-panel step button, asynchronous to CLK_osc.
- clkEn  output  1  one-cycle enable to the core: the core advances one instruction per high cycle.
- halted  output  1  high while in HALTED state (drives halt LED).
- enCount  output  CNT_W  number of clkEn pulses issued since reset.

Behaviour:
- Reset: async assert clears everything: sync flops, debounced levels, debounce counters, divCnt, stepPending, enCount=0, clkEn=0, state=RUN, halted=0.
- Synchronizers: HALT and STEP each pass through a 2-flop synchronizer.
- Debounce, one independent copy per input:
  - Counter clears whenever the synchronized level equals the debounced level.
  - Otherwise it increments.
  - When it would reach DEBOUNCE_CYCLES, the debounced level takes the synchronized level and the counter clears.
  - Raw-to-debounced latency is exactly 2+DEBOUNCE_CYCLES edges for a clean step input.
  - Any glitch shorter than DEBOUNCE_CYCLES is ignored.
- Step edge: a rising edge of debounced STEP (0→1) while state=HALTED sets stepPending=1.
  - Edges in RUN are ignored.
  - Multiple edges before the next tick collapse to one pending step.
- Divider:
  - divCnt counts 0..DIV-1 and wraps; it runs continuously in every state.
  - A tick is the edge on which divCnt==DIV-1.
  - First tick after reset release is rising edge number DIV.
- FSM, evaluated only on tick edges; off-tick edges leave state unchanged and force clkEn<=0.
  - RUN: if debounced HALT=1, go to HALTED with clkEn<=0. Else stay in RUN with clkEn<=1.
  - HALTED, debounced HALT=0: go to RUN with clkEn<=1, and clear stepPending.
  - HALTED, debounced HALT=1 and stepPending=1: clkEn<=1, clear stepPending, stay HALTED.
  - HALTED otherwise: clkEn<=0.
- clkEn is registered and is never high for two consecutive cycles.
- halted is registered and equals (state==HALTED).
- enCount increments on the same edge that sets clkEn<=1 and wraps modulo 2^CNT_W.
- Simultaneous events:
  - A step edge arriving on a tick edge is recorded as pending and serviced on the following tick, not the current one.
  - HALT deasserting while a step is pending yields exactly one pulse on the transition tick, not two.
- Reset mid-operation: a pending step and partial debounce progress are discarded, and the divider restarts from 0.

Test Plan (DIV=4, DEBOUNCE_CYCLES=3, CNT_W=4):
1. Release RST with HALT=0, STEP=0 → clkEn high after edges 4, 8, 12, …, one cycle each. enCount=1,2,3 after those edges. halted=0 throughout.
2. Raise HALT and hold → debounced after 5 edges. First tick after that gives no pulse and halted=1. No further clkEn for 40 cycles. enCount frozen.
3. While halted, press STEP for 10 cycles → exactly one clkEn on the first tick after debounced rise, and enCount +1. Two presses within one tick period → still exactly one pulse.
4. While halted, pulse STEP for 2 cycles (glitch) → no pulse. Debounced STEP stays 0.
5. While halted with a step pending, drop HALT → exactly one clkEn on the transition tick, then the normal period of 4 resumes. halted=0.
6. Assert RST asynchronously mid-period with a step pending → all outputs 0 immediately. After release, first clkEn at edge 4. Run 20 pulses → enCount wraps 15→0.
